// File: rtl/mm_line_responder.sv
// rtl/mm_line_responder.sv - line-granular main-memory responder with fixed latency
// Optional write-capture log built when MM_CAPTURE_EN is defined.
module mm_line_responder #(
   parameter int ADDR_W    = 26,
   parameter int LINE_W    = 256,
   parameter int MEM_LOG2  = 16,
   parameter int LATENCY   = 4,
   parameter int CAP_DEPTH = 16,
   localparam int CAP_IW   = $clog2(CAP_DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LINE_W-1:0] req_wd,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic [LINE_W-1:0] rsp_rd,
   input  logic [CAP_IW-1:0] cap_idx,
   output logic [31:0]       cap_addr,
   output logic [31:0]       cap_data,
   output logic [CAP_IW:0]   cap_count,
   output logic              cap_ovf
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   state_t              state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LINE_W-1:0]   wd_q;
   logic [LINE_W-1:0]   rsp_rd_q;

   logic                accept;
   logic                ent_resp;
   logic                ent_wr;
   logic [ADDR_W-1:0]   ent_addr;
   logic [LINE_W-1:0]   ent_wd;

   logic [LINE_W-1:0]   mem [1 << MEM_LOG2];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               cnt_d   = CNT_LOAD;
               state_d = (CNT_LOAD == 8'd0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // With LATENCY=1 the RESP entry coincides with accept, so the request
      // fields come straight from the inputs instead of the latches.
      ent_resp = (state_d == ST_RESP) && (state_q != ST_RESP) && !reset;
      ent_wr   = accept ? req_write : wr_q;
      ent_addr = accept ? req_addr  : addr_q;
      ent_wd   = accept ? req_wd    : wd_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 8'd0;
         wr_q     <= 1'b0;
         rsp_rd_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q   <= req_write;
            addr_q <= req_addr;
            wd_q   <= req_wd;
         end
         if (ent_resp && !ent_wr) rsp_rd_q <= mem[ent_addr[MEM_LOG2-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (ent_resp && ent_wr) mem[ent_addr[MEM_LOG2-1:0]] <= ent_wd;
   end

   assign rsp_write = wr_q;
   assign rsp_rd    = rsp_rd_q;

`ifdef MM_CAPTURE_EN
   localparam logic [CAP_IW:0] CAP_FULL = (CAP_IW + 1)'(CAP_DEPTH);

   logic [ADDR_W-1:0] cap_addr_mem [CAP_DEPTH];
   logic [31:0]       cap_data_mem [CAP_DEPTH];
   logic [CAP_IW:0]   cap_count_q;
   logic              cap_ovf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cap_count_q <= '0;
         cap_ovf_q   <= 1'b0;
      end else if (ent_resp && ent_wr) begin
         if (cap_count_q == CAP_FULL) cap_ovf_q <= 1'b1;
         else                         cap_count_q <= cap_count_q + 1'b1;
      end
   end

   // Entry storage has no reset so the log survives a bench-issued reset.
   always_ff @(posedge clk) begin
      if (ent_resp && ent_wr && (cap_count_q != CAP_FULL)) begin
         cap_addr_mem[cap_count_q[CAP_IW-1:0]] <= ent_addr;
         cap_data_mem[cap_count_q[CAP_IW-1:0]] <= ent_wd[31:0];
      end
   end

   assign cap_addr  = 32'(cap_addr_mem[cap_idx]);
   assign cap_data  = cap_data_mem[cap_idx];
   assign cap_count = cap_count_q;
   assign cap_ovf   = cap_ovf_q;
`else
   logic unused_cap;
   assign unused_cap = ^{cap_idx, ent_addr[ADDR_W-1:MEM_LOG2]};

   assign cap_addr  = 32'd0;
   assign cap_data  = 32'd0;
   assign cap_count = '0;
   assign cap_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_mm_line_responder.sv
// tb/tb_mm_line_responder.sv - directed bench for mm_line_responder (LATENCY 4 and 8 instances)
module tb_mm_line_responder;

   logic         clk;
   logic         reset, reset8;
   logic         req_valid, req_write;
   logic [25:0]  req_addr;
   logic [255:0] req_wd;
   logic         req_ready, rsp_valid, rsp_write;
   logic [255:0] rsp_rd;
   logic [3:0]   cap_idx;
   logic [31:0]  cap_addr, cap_data;
   logic [4:0]   cap_count;
   logic         cap_ovf;

   logic         req8_valid, req8_write;
   logic [25:0]  req8_addr;
   logic [255:0] req8_wd;
   logic         req8_ready, rsp8_valid, rsp8_write;
   logic [255:0] rsp8_rd;
   logic [3:0]   cap8_idx;
   logic [31:0]  cap8_addr, cap8_data;
   logic [4:0]   cap8_count;
   logic         cap8_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   mm_line_responder #(.LATENCY(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wd(req_wd),
      .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rd(rsp_rd),
      .cap_idx(cap_idx), .cap_addr(cap_addr), .cap_data(cap_data),
      .cap_count(cap_count), .cap_ovf(cap_ovf)
   );

   mm_line_responder #(.LATENCY(8)) dut8 (
      .clk(clk), .reset(reset8),
      .req_valid(req8_valid), .req_ready(req8_ready), .req_write(req8_write),
      .req_addr(req8_addr), .req_wd(req8_wd),
      .rsp_valid(rsp8_valid), .rsp_write(rsp8_write), .rsp_rd(rsp8_rd),
      .cap_idx(cap8_idx), .cap_addr(cap8_addr), .cap_data(cap8_data),
      .cap_count(cap8_count), .cap_ovf(cap8_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One request on the LATENCY=4 instance; starts and ends on a falling edge.
   task automatic txn4(input logic wr, input logic [25:0] a, input logic [255:0] wd,
                       input logic [255:0] exp_rd);
      @(negedge clk);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wd    = wd;
      check("ready_c0", req_ready, 1);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         check($sformatf("ready_c%0d", c), req_ready, (c == 5));
         check($sformatf("rsp_valid_c%0d", c), rsp_valid, (c == 4));
         if (c == 4) begin
            check("rsp_write", rsp_write, wr);
            check($sformatf("rsp_rd_a%0h", a), rsp_rd, exp_rd);
         end
      end
   endtask

   logic [255:0] line3, line55;
   int           pulses, accepts;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      for (int n = 0; n < 8; n++) line3[n*32 +: 32] = 32'hA000_0000 + 32'(n);
      line55 = {64{4'h5}};

      reset = 1'b1; reset8 = 1'b1;
      req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_wd = '0; cap_idx = '0;
      req8_valid = 1'b1; req8_write = 1'b0; req8_addr = '0; req8_wd = '0; cap8_idx = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0; reset8 = 1'b0;
      req_valid = 1'b0; req8_valid = 1'b0;
      check("rst_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_write", rsp_write, 0);
      check("rst_rsp_rd", rsp_rd, 0);
      check("rst_cap_count", cap_count, 0);
      check("rst_cap_ovf", cap_ovf, 0);
      check("rst_ready8", req8_ready, 1);

      txn4(1'b1, 26'h00003, line3, 256'd0);
      txn4(1'b0, 26'h00003, line3, line3);
      check("rd_word7", rsp_rd[255:224], 32'hA000_0007);

      txn4(1'b1, 26'h10005, line55, line3);
      txn4(1'b0, 26'h00005, line55, line55);
      txn4(1'b0, 26'h00009, 256'd0, 256'd0);

      // Back-to-back: req_valid held for three accepts.
      pulses = 0; accepts = 0;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 26'h00003;
      for (int c = 0; c <= 15; c++) begin
         if (c == 11) req_valid = 1'b0;
         check($sformatf("b2b_ready_c%0d", c), req_ready, (c % 5 == 0));
         check($sformatf("b2b_rsp_c%0d", c), rsp_valid, (c % 5 == 4));
         if (rsp_valid) pulses++;
         if (req_valid && req_ready) accepts++;
         if (c == 14) check("b2b_rd", rsp_rd, line3);
         @(negedge clk);
      end
      check("b2b_pulses", pulses, 3);
      check("b2b_accepts", accepts, 3);

      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst2_cap_count", cap_count, 0);
      check("rst2_rsp_rd", rsp_rd, 0);
      for (int k = 0; k <= 16; k++) begin
`ifdef MM_CAPTURE_EN
         if (k == 16) begin
            check("cap_count_full", cap_count, 16);
            check("cap_ovf_pre", cap_ovf, 0);
         end
`endif
         txn4(1'b1, 26'(k), 256'(k), 256'd0);
      end
      cap_idx = 4'd15;
      #1;
`ifdef MM_CAPTURE_EN
      check("cap_count", cap_count, 16);
      check("cap_ovf", cap_ovf, 1);
      check("cap_addr15", cap_addr, 15);
      check("cap_data15", cap_data, 15);
      cap_idx = 4'd0;
      #1;
      check("cap_addr0", cap_addr, 0);
      check("cap_data0", cap_data, 0);
`else
      check("cap_count_off", cap_count, 0);
      check("cap_ovf_off", cap_ovf, 0);
      check("cap_addr_off", cap_addr, 0);
      check("cap_data_off", cap_data, 0);
`endif
      txn4(1'b0, 26'h00010, 256'd0, 256'd16);
      txn4(1'b0, 26'h00003, 256'd0, 256'd3);

      // LATENCY=8 instance: reset during WAIT drops the pending write.
      @(negedge clk);
      req8_valid = 1'b1; req8_write = 1'b1; req8_addr = 26'h00007; req8_wd = '1;
      check("r8_ready_c0", req8_ready, 1);
      pulses = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) req8_valid = 1'b0;
         if (c == 3) reset8 = 1'b1;
         if (c == 4) begin
            reset8 = 1'b0;
            check("r8_ready_after_rst", req8_ready, 1);
         end
         if (rsp8_valid) pulses++;
      end
      check("r8_no_rsp", pulses, 0);

      @(negedge clk);
      req8_valid = 1'b1; req8_write = 1'b0; req8_addr = 26'h00007; req8_wd = '0;
      check("r8rd_ready_c0", req8_ready, 1);
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (c == 1) req8_valid = 1'b0;
         check($sformatf("r8rd_rsp_c%0d", c), rsp8_valid, (c == 8));
         if (c == 8) begin
            check("r8rd_write", rsp8_write, 0);
            check("r8rd_data", rsp8_rd, 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
